seg7_bcd_scan_driver: RTL
=========================

// Module: seg7_bcd_scan_driver
// PURPOSE
//  Downstream display stage for the reaction-timer core. Accepts a binary millisecond
//  value over a valid/ready handshake and converts it to 4-digit BCD with a sequential
//  double-dabble (one bit per cycle). Drives the 4 right-hand digits of the 8-digit
//  active-low seven-segment display through a time-multiplexed scan, so the timer core
//  holds no display logic.
// PARAMETERS
//  BIN_W    14       width of bin_in (max 16383)
//  SCAN_DIV 100_000  clock cycles per digit slot (1 kHz/digit at 100 MHz); min 2
//  LZB      1        1 = blank leading zeros (digit 0 always shown); 0 = show all 4 digits
// PORTS
//  CLK100MHZ   in   1      system clock, all logic on rising edge
//  CPU_RESETN  in   1      synchronous active-low reset
//  bin_in      in   BIN_W  binary value in ms, sampled on accept
//  bin_valid   in   1      request; accept = bin_valid && bin_ready at a clock edge
//  bin_ready   out  1      high when the converter is idle
//  blank       in   1      1 = display dark (AN all 1, seg all 1)
//  bcd_out     out  16     committed BCD {d3,d2,d1,d0}, d0 = ones
//  conv_done   out  1      one-cycle pulse when bcd_out updates
//  AN          out  8      digit anodes, active low; AN[7:4] held 1
//  seg         out  8      {DP,CG,CF,CE,CD,CC,CB,CA}, active low; DP always 1
// BEHAVIOUR
//  Reset (CPU_RESETN=0 at an edge): FSM=IDLE, bin_ready=1, bcd_out=0, conv_done=0,
//   AN=8'hFF, seg=8'hFF, scan counter=0, digit index=0. A reset mid-conversion aborts
//   the conversion and leaves bcd_out=0.
//  Converter FSM: IDLE -> SHIFT -> LOAD -> IDLE.
//   IDLE: bin_ready=1. On accept at edge E0, latch operand = (bin_in > 9999) ? 9999 : bin_in.
//    Clear the BCD scratch and the bit counter, then go to SHIFT.
//   SHIFT: bin_ready=0. Each cycle, add 3 to every scratch nibble >= 5, then shift
//    {scratch,operand} left by 1. After BIN_W shifts (edge E14 for BIN_W=14), go to LOAD.
//   LOAD: at edge E15, bcd_out <= scratch, conv_done=1 for the next cycle, bin_ready=1.
//  Latency: accept-to-bcd_out = BIN_W+1 cycles (15). Throughput: one value per 16 cycles.
//  bin_valid while bin_ready=0 is ignored, with no queueing. bin_valid held high in IDLE
//   re-accepts on the cycle after LOAD.
//  Scan: counter runs 0..SCAN_DIV-1 and wraps. At terminal count, digit index 0->1->2->3->0.
//   AN and seg are registered from the index and digit: an index change is visible 1 cycle later.
//   AN[idx] = 0, all other AN = 1. seg = font(bcd_out nibble idx).
//   Font: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90; non-BCD nibble = FF.
//   LZB=1: digit i>0 is blanked (its AN stays 1, seg=FF) when nibbles i..3 are all zero.
//   blank=1: the next registered AN=8'hFF and seg=8'hFF. The scan counter keeps running.
//  Display and scan are independent of the converter. The display shows the old bcd_out
//   until LOAD. A new bcd_out takes effect at the current slot's next register update,
//   without restarting the scan.
// TESTING (bench uses SCAN_DIV=4)
//  1. Reset, release -> AN=FF, seg=FF, bin_ready=1. After the first scan register update:
//     AN=FE, seg=C0 ("0"). AN[3:1] never low (LZB=1).
//  2. bin_in=1234 with a 1-cycle valid -> bin_ready low 15 cycles; bcd_out=16'h1234 with
//     conv_done at cycle 15. Scan gives AN0:99, AN1:B0, AN2:A4, AN3:F9.
//  3. bin_in=10000, then 16383 -> bcd_out=16'h9999 both times; seg=90 on all 4 digits.
//  4. bin_in=7 -> only AN0 goes low (seg=F8). bin_in=1005 -> all 4 lit (F9,C0,C0,92).
//     With LZB=0, bin_in=7 lights C0,C0,C0,F8.
//  5. Accept 1234, then valid with 5555 at cycles 3 and 10 -> both ignored, bcd_out=1234.
//     Valid held with 4321 -> accepted on the cycle after LOAD, bcd_out=4321 16 cycles later.
//  6. CPU_RESETN=0 during SHIFT cycle 7 -> next cycle bin_ready=1, bcd_out=0, no conv_done.
//     blank=1 -> AN=FF, seg=FF one cycle later; blank=0 resumes at the current index.

Source files
------------

// File: rtl/seg7_bcd_scan_driver.sv
// Binary-to-BCD display stage: sequential double-dabble converter feeding a
// 4-digit time-multiplexed active-low seven-segment scan with leading-zero blanking.
module seg7_bcd_scan_driver #(
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 100_000,
    parameter int LZB      = 1
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             bin_ready,
    input  logic             blank,
    output logic [15:0]      bcd_out,
    output logic             conv_done,
    output logic [7:0]       AN,
    output logic [7:0]       seg
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [BIN_W-1:0] BCD_MAX   = BIN_W'(32'd9999);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BIN_W - 1);
    localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    function automatic logic [15:0] dabble_adj(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] font(input logic [3:0] d);
        logic [7:0] f;
        case (d)
            4'd0:    f = 8'hC0;
            4'd1:    f = 8'hF9;
            4'd2:    f = 8'hA4;
            4'd3:    f = 8'hB0;
            4'd4:    f = 8'h99;
            4'd5:    f = 8'h92;
            4'd6:    f = 8'h82;
            4'd7:    f = 8'hF8;
            4'd8:    f = 8'h80;
            4'd9:    f = 8'h90;
            default: f = 8'hFF;
        endcase
        return f;
    endfunction

    state_t             state_q;
    logic               bin_ready_q;
    logic               conv_done_q;
    logic [15:0]        bcd_q;
    logic [15:0]        scratch_q, scratch_d, adj_s;
    logic [BIN_W-1:0]   operand_q, operand_d;
    logic [CNT_W-1:0]   bit_cnt_q;

    logic [SC_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic [3:0]         digit_s;
    logic               lead_zero_s;

    // One double-dabble step: correct nibbles, then shift the operand MSB into the scratch
    always_comb begin
        adj_s     = dabble_adj(scratch_q);
        scratch_d = (adj_s << 1) | {15'd0, operand_q[BIN_W-1]};
        operand_d = operand_q << 1;
    end

    // Converter FSM; bcd_out only changes in LOAD so the display never sees partial results
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state_q     <= ST_IDLE;
            bin_ready_q <= 1'b1;
            conv_done_q <= 1'b0;
            bcd_q       <= 16'd0;
            scratch_q   <= 16'd0;
            operand_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            conv_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bin_valid) begin
                        operand_q   <= (bin_in > BCD_MAX) ? BCD_MAX : bin_in;
                        scratch_q   <= 16'd0;
                        bit_cnt_q   <= '0;
                        bin_ready_q <= 1'b0;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= scratch_d;
                    operand_q <= operand_d;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bcd_q       <= scratch_q;
                    conv_done_q <= 1'b1;
                    bin_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    bin_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan timebase plus the anode/segment pattern for the current slot
    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SC_W'(1);
            idx_d      = idx_q;
        end
        digit_s = bcd_q[4*idx_q +: 4];
        case (idx_q)
            2'd1:    lead_zero_s = (bcd_q[15:4] == 12'd0);
            2'd2:    lead_zero_s = (bcd_q[15:8] == 8'd0);
            2'd3:    lead_zero_s = (bcd_q[15:12] == 4'd0);
            default: lead_zero_s = 1'b0;
        endcase
        if (blank || ((LZB != 0) && lead_zero_s)) begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = font(digit_s);
        end
    end

    // Scan registers; the drive pattern refreshes every cycle so new data shows mid-slot
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bin_ready = bin_ready_q;
    assign conv_done = conv_done_q;
    assign bcd_out   = bcd_q;
    assign AN        = an_q;
    assign seg       = seg_q;

endmodule
